v_lsu_seq: RTL and testbench
============================

Name: v_lsu_seq

Overview:
- Vector load/store sequencer; sits directly upstream of the vector memory stage.
- Accepts one unit-stride whole-register vector load or store command from the vector execute stage.
- Breaks the command into one VLEN-wide VRAM access per vector register (1..8 registers).
- Drives the vmem request port, reads the VRF for stores, and writes VRF for loads; pulses done on completion.

Parameters:
- VLEN, 512, vector register / VRAM row width in bits.
- ADDR_W, 64, vmem byte-address width.
- VREG_W, 5, vector register index width (32 registers).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lsu_valid_i  in  1  command valid.
- lsu_ready_o  out  1  sequencer can accept a command.
- lsu_is_store_i  in  1  1 = store (VRF→VRAM), 0 = load (VRAM→VRF).
- lsu_base_addr_i  in  ADDR_W  byte base address.
- lsu_vreg_i  in  VREG_W  first vector register of the group.
- lsu_nreg_i  in  3  register count minus 1 (0→1 reg … 7→8 regs).
- lsu_done_o  out  1  one-cycle completion pulse.
- vrf_raddr_o  out  VREG_W  VRF read index (store data).
- vrf_rdata_i  in  VLEN  VRF read data, combinational from vrf_raddr_o.
- vrf_wen_o  out  1  VRF write enable (load data).
- vrf_waddr_o  out  VREG_W  VRF write index.
- vrf_wdata_o  out  VLEN  VRF write data.
- vmem_ren_o  out  1  vmem read request.
- vmem_wen_o  out  1  vmem write request.
- vmem_addr_o  out  ADDR_W  vmem byte address.
- vmem_din_o  out  VLEN  vmem write data.
- vmem_dout_i  in  VLEN  vmem read data, valid exactly 1 cycle after vmem_ren_o.

Behaviour:
- Reset values: all outputs 0 except lsu_ready_o = 1. State = IDLE; counters and latched fields = 0.
- States:
  - IDLE: lsu_ready_o = 1. On lsu_valid_i, latch is_store, base, vreg and nreg; clear k. Go to LOAD or STORE.
  - LOAD: vmem_ren_o = 1; vmem_addr_o = base_al + k*(VLEN/8); k increments each cycle. After the access with k = nreg, go to LTAIL.
  - LTAIL: no vmem request; completes the last VRF write; go to DONE.
  - STORE: vmem_wen_o = 1; vmem_addr_o as in LOAD; vrf_raddr_o = vreg+k; vmem_din_o = vrf_rdata_i. After the access with k = nreg, go to DONE.
  - DONE: lsu_done_o = 1 for exactly one cycle; lsu_ready_o = 0; go to IDLE.
- Load writeback: a registered pending flag and index. In the cycle after each read, vrf_wen_o = 1, vrf_waddr_o = vreg + (k of that read), vrf_wdata_o = vmem_dout_i. Back-to-back reads overlap the previous writeback, one per cycle.
- Latency (accept at cycle T, N = nreg+1):
  - Load: reads at T+1..T+N; VRF writes at T+2..T+N+1; done at T+N+2.
  - Store: writes at T+1..T+N; done at T+N+1.
- base_al = lsu_base_addr_i with the low log2(VLEN/8) bits forced to 0 (misaligned bits silently dropped).
- Address sum wraps modulo 2^ADDR_W.
- Register index vreg+k wraps modulo 2^VREG_W (e.g. v30, N = 4 → v30, v31, v0, v1).
- vmem_ren_o and vmem_wen_o are never high in the same cycle. vrf_wen_o is never high during STORE.
- vmem_addr_o, vmem_ren_o and vmem_wen_o are driven only from registered state; no combinational path from lsu_* inputs.
- Outside active states, vmem_addr_o, vmem_din_o and vrf_raddr_o are 0.
- lsu_valid_i while lsu_ready_o = 0 is ignored; no queuing. Command fields matter only at the accept edge.
- A new command can be accepted on the cycle after DONE at the earliest.
- Reset asserted mid-operation: immediate return to IDLE; all requests and VRF writes deassert asynchronously; no done pulse; the partial transfer is not completed.

Test Plan:
- Single load: vreg = 3, nreg = 0, base = 0x8100_0000, VRAM row = pattern A → ren at T+1 with addr 0x8100_0000; vrf write v3 = A at T+2; done at T+3; ready high again at T+4.
- Store group: vreg = 8, nreg = 3, base = 0x8100_0100, VLEN = 512 → wen at T+1..T+4 with addrs 0x…0100, 0x…0140, 0x…0180, 0x…01C0; din = v8..v11 contents; done at T+5; ren stays 0 throughout.
- Wrap: load vreg = 30, nreg = 3 → VRF writes to v30, v31, v0, v1 in consecutive cycles; misaligned base 0x8100_0013 produces first addr 0x8100_0000.
- Busy rejection: assert lsu_valid_i with a different command during an active load → ignored; only the original accesses occur; the second command is accepted only once ready = 1.
- Reset mid-store: assert rst_n = 0 after 2 of 8 writes → wen drops immediately; no done pulse; after release ready = 1; a new single load completes normally.
- Invariant check across random commands: ren & wen never both 1; exactly one done pulse per accepted command; the number of vmem accesses equals nreg+1.

Source files
------------

// File: rtl/v_lsu_seq.sv
// Vector load/store sequencer: splits one unit-stride whole-register command
// into one VLEN-wide vmem access per register, with VRF read/writeback.
module v_lsu_seq #(
  parameter int VLEN   = 512,
  parameter int ADDR_W = 64,
  parameter int VREG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic              lsu_is_store_i,
  input  logic [ADDR_W-1:0] lsu_base_addr_i,
  input  logic [VREG_W-1:0] lsu_vreg_i,
  input  logic [2:0]        lsu_nreg_i,
  output logic              lsu_done_o,
  output logic [VREG_W-1:0] vrf_raddr_o,
  input  logic [VLEN-1:0]   vrf_rdata_i,
  output logic              vrf_wen_o,
  output logic [VREG_W-1:0] vrf_waddr_o,
  output logic [VLEN-1:0]   vrf_wdata_o,
  output logic              vmem_ren_o,
  output logic              vmem_wen_o,
  output logic [ADDR_W-1:0] vmem_addr_o,
  output logic [VLEN-1:0]   vmem_din_o,
  input  logic [VLEN-1:0]   vmem_dout_i
);

  localparam int ROW_BYTES = VLEN / 8;
  localparam int ROW_SHIFT = $clog2(ROW_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(ROW_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LTAIL,
    S_STORE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [VREG_W-1:0]   vreg_q, vreg_d;
  logic [2:0]          nreg_q, nreg_d;
  logic [2:0]          k_q, k_d;
  logic                pend_q, pend_d;
  logic [VREG_W-1:0]   widx_q, widx_d;

  logic                last_beat;
  logic [VREG_W-1:0]   cur_idx;
  logic [ADDR_W-1:0]   cur_addr;

  // Both sums wrap naturally at their declared widths.
  assign last_beat = (k_q == nreg_q);
  assign cur_idx   = vreg_q + VREG_W'(k_q);
  assign cur_addr  = base_q + (ADDR_W'(k_q) << ROW_SHIFT);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    vreg_d  = vreg_q;
    nreg_d  = nreg_q;
    k_d     = k_q;
    // Each load beat leaves a writeback pending for the following cycle.
    pend_d  = (state_q == S_LOAD);
    widx_d  = (state_q == S_LOAD) ? cur_idx : widx_q;

    case (state_q)
      S_IDLE: begin
        if (lsu_valid_i) begin
          base_d  = lsu_base_addr_i & ALIGN_MASK;
          vreg_d  = lsu_vreg_i;
          nreg_d  = lsu_nreg_i;
          k_d     = 3'd0;
          state_d = lsu_is_store_i ? S_STORE : S_LOAD;
        end
      end
      S_LOAD: begin
        k_d = k_q + 3'd1;
        if (last_beat) begin
          k_d     = 3'd0;
          state_d = S_LTAIL;
        end
      end
      S_LTAIL: begin
        state_d = S_DONE;
      end
      S_STORE: begin
        k_d = k_q + 3'd1;
        if (last_beat) begin
          k_d     = 3'd0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      vreg_q  <= '0;
      nreg_q  <= '0;
      k_q     <= '0;
      pend_q  <= 1'b0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      vreg_q  <= vreg_d;
      nreg_q  <= nreg_d;
      k_q     <= k_d;
      pend_q  <= pend_d;
      widx_q  <= widx_d;
    end
  end

  // All request outputs decode only flopped state, so reset clears them at once.
  always_comb begin
    lsu_ready_o = (state_q == S_IDLE);
    lsu_done_o  = (state_q == S_DONE);
    vmem_ren_o  = (state_q == S_LOAD);
    vmem_wen_o  = (state_q == S_STORE);
    vmem_addr_o = (vmem_ren_o || vmem_wen_o) ? cur_addr : '0;
    vrf_raddr_o = vmem_wen_o ? cur_idx : '0;
    vmem_din_o  = vmem_wen_o ? vrf_rdata_i : '0;
    vrf_wen_o   = pend_q;
    vrf_waddr_o = pend_q ? widx_q : '0;
    vrf_wdata_o = pend_q ? vmem_dout_i : '0;
  end

endmodule

// File: tb/tb_v_lsu_seq.sv
// Directed and randomised checks for v_lsu_seq against a cycle-level
// expectation model with behavioural VRF and VRAM.
module tb_v_lsu_seq;
  localparam int VLEN = 512;
  localparam int ADDR_W = 64;
  localparam int VREG_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              lsu_valid;
  logic              lsu_ready;
  logic              lsu_is_store;
  logic [ADDR_W-1:0] lsu_base;
  logic [VREG_W-1:0] lsu_vreg;
  logic [2:0]        lsu_nreg;
  logic              lsu_done;
  logic [VREG_W-1:0] vrf_raddr;
  logic [VLEN-1:0]   vrf_rdata;
  logic              vrf_wen;
  logic [VREG_W-1:0] vrf_waddr;
  logic [VLEN-1:0]   vrf_wdata;
  logic              vmem_ren;
  logic              vmem_wen;
  logic [ADDR_W-1:0] vmem_addr;
  logic [VLEN-1:0]   vmem_din;
  logic [VLEN-1:0]   vmem_dout;

  int n_vec = 0;
  int n_bad = 0;

  logic [VLEN-1:0] vrf_mem [32];

  always #5 clk = ~clk;

  v_lsu_seq #(.VLEN(VLEN), .ADDR_W(ADDR_W), .VREG_W(VREG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready),
    .lsu_is_store_i(lsu_is_store), .lsu_base_addr_i(lsu_base),
    .lsu_vreg_i(lsu_vreg), .lsu_nreg_i(lsu_nreg), .lsu_done_o(lsu_done),
    .vrf_raddr_o(vrf_raddr), .vrf_rdata_i(vrf_rdata),
    .vrf_wen_o(vrf_wen), .vrf_waddr_o(vrf_waddr), .vrf_wdata_o(vrf_wdata),
    .vmem_ren_o(vmem_ren), .vmem_wen_o(vmem_wen), .vmem_addr_o(vmem_addr),
    .vmem_din_o(vmem_din), .vmem_dout_i(vmem_dout)
  );

  function automatic logic [VLEN-1:0] pattern(input logic [ADDR_W-1:0] a);
    return {16{a[31:0] ^ 32'hA5A5_0000}};
  endfunction

  assign vrf_rdata = vrf_mem[vrf_raddr];

  always @(posedge clk) vmem_dout <= vmem_ren ? pattern(vmem_addr) : '0;

  typedef struct {
    bit                is_store;
    logic [ADDR_W-1:0] base;
    logic [VREG_W-1:0] vreg;
    logic [2:0]        nreg;
    logic [ADDR_W-1:0] exp_addr0;
    bit                poke;
  } cmd_t;

  task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Issue one command and check every output cycle by cycle until ready returns.
  task automatic run_cmd(input cmd_t c);
    int n;
    int last;
    logic [ADDR_W-1:0] a;
    logic [VREG_W-1:0] ri;
    n = int'(c.nreg) + 1;
    last = c.is_store ? n + 2 : n + 3;
    @(negedge clk);
    chk("ready_before_accept", lsu_ready, 1'b1);
    lsu_valid = 1'b1;
    lsu_is_store = c.is_store;
    lsu_base = c.base;
    lsu_vreg = c.vreg;
    lsu_nreg = c.nreg;
    $display("cmd %s base=%h vreg=%0d nreg=%0d poke=%0d",
             c.is_store ? "store" : "load", c.base, c.vreg, c.nreg, c.poke);
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      if (c.is_store) begin
        a  = c.exp_addr0 + ADDR_W'(i - 1) * 64;
        ri = c.vreg + VREG_W'(i - 1);
        chk("st_wen", vmem_wen, i <= n);
        chk("st_ren", vmem_ren, 1'b0);
        chk("st_addr", vmem_addr, (i <= n) ? a : '0);
        chk("st_raddr", vrf_raddr, (i <= n) ? ri : '0);
        chk("st_din", vmem_din, (i <= n) ? vrf_mem[ri] : '0);
        chk("st_vrf_wen", vrf_wen, 1'b0);
        chk("st_done", lsu_done, i == n + 1);
        chk("st_ready", lsu_ready, i == n + 2);
      end else begin
        a = c.exp_addr0 + ADDR_W'(i - 1) * 64;
        chk("ld_ren", vmem_ren, i <= n);
        chk("ld_wen", vmem_wen, 1'b0);
        chk("ld_addr", vmem_addr, (i <= n) ? a : '0);
        chk("ld_vrf_wen", vrf_wen, (i >= 2) && (i <= n + 1));
        if ((i >= 2) && (i <= n + 1)) begin
          ri = c.vreg + VREG_W'(i - 2);
          chk("ld_waddr", vrf_waddr, ri);
          chk("ld_wdata", vrf_wdata, pattern(c.exp_addr0 + ADDR_W'(i - 2) * 64));
        end
        chk("ld_done", lsu_done, i == n + 2);
        chk("ld_ready", lsu_ready, i == n + 3);
      end
      if (c.poke && i <= n + 1) begin
        lsu_valid = 1'b1;
        lsu_is_store = ~c.is_store;
        lsu_base = 64'h1234_5000;
        lsu_vreg = c.vreg + 5'd7;
        lsu_nreg = 3'd2;
      end else begin
        lsu_valid = 1'b0;
      end
    end
    lsu_valid = 1'b0;
  endtask

  cmd_t vecs [6];

  initial begin
    int overlap;
    int acc;
    int dones;
    cmd_t c;

    for (int i = 0; i < 32; i++) vrf_mem[i] = {16{32'hC0DE_0000 | 32'(i)}};
    vecs[0] = '{1'b0, 64'h0000_0000_8100_0000, 5'd3,  3'd0, 64'h0000_0000_8100_0000, 1'b0};
    vecs[1] = '{1'b1, 64'h0000_0000_8100_0100, 5'd8,  3'd3, 64'h0000_0000_8100_0100, 1'b0};
    vecs[2] = '{1'b0, 64'h0000_0000_8100_0013, 5'd30, 3'd3, 64'h0000_0000_8100_0000, 1'b0};
    vecs[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFC5, 5'd31, 3'd1, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0};
    vecs[4] = '{1'b0, 64'h0000_0000_0000_1000, 5'd5,  3'd7, 64'h0000_0000_0000_1000, 1'b1};
    vecs[5] = '{1'b1, 64'h0000_0000_0000_2040, 5'd1,  3'd2, 64'h0000_0000_0000_2040, 1'b0};

    rst_n = 1'b0;
    lsu_valid = 1'b0;
    lsu_is_store = 1'b0;
    lsu_base = '0;
    lsu_vreg = '0;
    lsu_nreg = '0;
    #12;
    chk("rst_ready", lsu_ready, 1'b1);
    chk("rst_done", lsu_done, 1'b0);
    chk("rst_ren", vmem_ren, 1'b0);
    chk("rst_wen", vmem_wen, 1'b0);
    chk("rst_vrf_wen", vrf_wen, 1'b0);
    chk("rst_addr", vmem_addr, '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[v]) run_cmd(vecs[v]);

    // Reset in the middle of an 8-register store.
    @(negedge clk);
    lsu_valid = 1'b1;
    lsu_is_store = 1'b1;
    lsu_base = 64'h0000_0000_8200_0000;
    lsu_vreg = 5'd0;
    lsu_nreg = 3'd7;
    $display("cmd store base=%h vreg=0 nreg=7 with mid-transfer reset", lsu_base);
    @(negedge clk);
    lsu_valid = 1'b0;
    chk("mid_wen1", vmem_wen, 1'b1);
    @(negedge clk);
    chk("mid_wen2", vmem_wen, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", vmem_wen, 1'b0);
    chk("mid_rst_addr", vmem_addr, '0);
    chk("mid_rst_ready", lsu_ready, 1'b1);
    chk("mid_rst_done", lsu_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      dones += int'(lsu_done);
      acc += int'(vmem_wen | vmem_ren);
    end
    chk("mid_no_done", 32'(dones), 32'd0);
    chk("mid_no_access", 32'(acc), 32'd0);
    run_cmd(vecs[0]);

    // Random commands: invariant checks only.
    for (int r = 0; r < 10; r++) begin
      c.is_store = 1'($urandom_range(0, 1));
      c.base = {32'h0, $urandom};
      c.vreg = 5'($urandom_range(0, 31));
      c.nreg = 3'($urandom_range(0, 7));
      @(negedge clk);
      chk("rnd_ready", lsu_ready, 1'b1);
      lsu_valid = 1'b1;
      lsu_is_store = c.is_store;
      lsu_base = c.base;
      lsu_vreg = c.vreg;
      lsu_nreg = c.nreg;
      $display("cmd rnd %s base=%h vreg=%0d nreg=%0d",
               c.is_store ? "store" : "load", c.base, c.vreg, c.nreg);
      overlap = 0;
      acc = 0;
      dones = 0;
      for (int i = 0; i < 14; i++) begin
        @(negedge clk);
        lsu_valid = 1'b0;
        overlap += int'(vmem_ren & vmem_wen);
        overlap += int'(vmem_wen & vrf_wen);
        acc += int'(vmem_ren | vmem_wen);
        dones += int'(lsu_done);
      end
      chk("rnd_overlap", 32'(overlap), 32'd0);
      chk("rnd_accesses", 32'(acc), 32'(int'(c.nreg) + 1));
      chk("rnd_dones", 32'(dones), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
